// File: rtl/scrypt_pkg.sv
// Shared definitions for the scrypt datapath: operand widths, scheduler
// state encoding and a small width helper.
package scrypt_pkg;

    localparam int BLOCK_W    = 1024;
    localparam int HASH_W     = 256;
    localparam int WAIT_CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } sched_state_t;

    // Index width that stays legal for a single requester.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester above last_grant,
// wrapping from the top index back to zero.
module rr_arbiter
    import scrypt_pkg::*;
#(
    parameter  int N_REQ = 4,
    localparam int IDW   = idx_width(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDW-1:0]   last_grant,
    output logic [N_REQ-1:0] grant,
    output logic             any
);

    logic [IDW-1:0]   cand [N_REQ];
    logic [N_REQ-1:0] hit;

    // cand[k] is the requester k+1 places after the previous winner.
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_offset
        assign cand[gi] = IDW'((int'(last_grant) + gi + 1) % N_REQ);
        assign hit[gi]  = req[cand[gi]];
    end

    always_comb begin
        grant = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (hit[k]) begin
                grant           = '0;
                grant[cand[k]]  = 1'b1;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/pbkdf2_2_sched.sv
// Shares one pbkdf2_2 core between N_REQ ROMix requesters: round-robin
// accept, core issue, bounded wait for the result, one-hot response.
module pbkdf2_2_sched
    import scrypt_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int INIT_CYCLES = 2,
    parameter int TIMEOUT     = 4096
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req_valid,
    output logic [N_REQ-1:0]          req_ready,
    input  logic [N_REQ*BLOCK_W-1:0]  req_data,
    input  logic [N_REQ*HASH_W-1:0]   req_ixor,
    input  logic [N_REQ*HASH_W-1:0]   req_oxor,
    output logic                      core_init,
    output logic [BLOCK_W-1:0]        core_in,
    output logic [HASH_W-1:0]         core_ixor_hash,
    output logic [HASH_W-1:0]         core_oxor_hash,
    input  logic                      core_valid,
    input  logic [HASH_W-1:0]         core_out,
    output logic [N_REQ-1:0]          rsp_valid,
    input  logic [N_REQ-1:0]          rsp_ready,
    output logic [HASH_W-1:0]         rsp_data,
    output logic                      rsp_err,
    output logic                      busy,
    output logic [31:0]               jobs_done
);

    localparam int IDW = idx_width(N_REQ);

    sched_state_t            state_reg;
    logic [IDW-1:0]          last_grant_reg;
    logic [IDW-1:0]          id_reg;
    logic [WAIT_CNT_W-1:0]   cnt_reg;
    logic                    core_init_reg;
    logic [BLOCK_W-1:0]      core_in_reg;
    logic [HASH_W-1:0]       core_ixor_reg;
    logic [HASH_W-1:0]       core_oxor_reg;
    logic [N_REQ-1:0]        rsp_valid_reg;
    logic [HASH_W-1:0]       rsp_data_reg;
    logic                    rsp_err_reg;
    logic [31:0]             jobs_done_reg;

    logic [N_REQ-1:0]        grant;
    logic                    grant_any;
    logic [IDW-1:0]          grant_idx;
    logic [N_REQ-1:0]        id_onehot;

    logic [BLOCK_W-1:0]      data_slice [N_REQ];
    logic [HASH_W-1:0]       ixor_slice [N_REQ];
    logic [HASH_W-1:0]       oxor_slice [N_REQ];

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slice
        assign data_slice[gi] = req_data[gi*BLOCK_W +: BLOCK_W];
        assign ixor_slice[gi] = req_ixor[gi*HASH_W +: HASH_W];
        assign oxor_slice[gi] = req_oxor[gi*HASH_W +: HASH_W];
    end

    rr_arbiter #(
        .N_REQ(N_REQ)
    ) u_arb (
        .req       (req_valid),
        .last_grant(last_grant_reg),
        .grant     (grant),
        .any       (grant_any)
    );

    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) grant_idx = IDW'(i);
        end
    end

    assign id_onehot = N_REQ'(1) << id_reg;

    // Ready is combinational so a pending request is accepted in its first IDLE cycle.
    assign req_ready = (state_reg == IDLE) ? grant : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            last_grant_reg <= IDW'(N_REQ - 1);
            id_reg         <= '0;
            cnt_reg        <= '0;
            core_init_reg  <= 1'b0;
            core_in_reg    <= '0;
            core_ixor_reg  <= '0;
            core_oxor_reg  <= '0;
            rsp_valid_reg  <= '0;
            rsp_data_reg   <= '0;
            rsp_err_reg    <= 1'b0;
            jobs_done_reg  <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (grant_any) begin
                        id_reg        <= grant_idx;
                        core_in_reg   <= data_slice[grant_idx];
                        core_ixor_reg <= ixor_slice[grant_idx];
                        core_oxor_reg <= oxor_slice[grant_idx];
                        core_init_reg <= 1'b1;
                        cnt_reg       <= '0;
                        state_reg     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (cnt_reg == WAIT_CNT_W'(INIT_CYCLES - 1)) begin
                        core_init_reg <= 1'b0;
                        cnt_reg       <= '0;
                        state_reg     <= WAIT;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                WAIT: begin
                    if (core_valid) begin
                        rsp_data_reg  <= core_out;
                        rsp_err_reg   <= 1'b0;
                        rsp_valid_reg <= id_onehot;
                        state_reg     <= RESP;
                    end else if (cnt_reg == WAIT_CNT_W'(TIMEOUT - 1)) begin
                        rsp_data_reg  <= '0;
                        rsp_err_reg   <= 1'b1;
                        rsp_valid_reg <= id_onehot;
                        state_reg     <= RESP;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready[id_reg]) begin
                        rsp_valid_reg  <= '0;
                        last_grant_reg <= id_reg;
                        if (!rsp_err_reg) jobs_done_reg <= jobs_done_reg + 32'd1;
                        state_reg      <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign core_init      = core_init_reg;
    assign core_in        = core_in_reg;
    assign core_ixor_hash = core_ixor_reg;
    assign core_oxor_hash = core_oxor_reg;
    assign rsp_valid      = rsp_valid_reg;
    assign rsp_data       = rsp_data_reg;
    assign rsp_err        = rsp_err_reg;
    assign busy           = (state_reg != IDLE);
    assign jobs_done      = jobs_done_reg;

endmodule

// File: tb/tb_pbkdf2_2_sched.sv
// Scoreboard bench for pbkdf2_2_sched with a 10-cycle behavioural core.
`timescale 1ns/1ps
module tb_pbkdf2_2_sched;
    import scrypt_pkg::*;

    localparam int N        = 4;
    localparam int INIT_CYC = 2;
    localparam int TMO      = 16;
    localparam int CORE_LAT = 10;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [N-1:0]         req_valid = '0;
    logic [N-1:0]         req_ready;
    logic [N*BLOCK_W-1:0] req_data = '0;
    logic [N*HASH_W-1:0]  req_ixor = '0;
    logic [N*HASH_W-1:0]  req_oxor = '0;
    logic                 core_init;
    logic [BLOCK_W-1:0]   core_in;
    logic [HASH_W-1:0]    core_ixor_hash;
    logic [HASH_W-1:0]    core_oxor_hash;
    logic                 core_valid = 1'b0;
    logic [HASH_W-1:0]    core_out = '0;
    logic [N-1:0]         rsp_valid;
    logic [N-1:0]         rsp_ready = '0;
    logic [HASH_W-1:0]    rsp_data;
    logic                 rsp_err;
    logic                 busy;
    logic [31:0]          jobs_done;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int                id;
        logic [HASH_W-1:0] data;
        logic              err;
    } exp_t;
    exp_t sb[$];

    logic [BLOCK_W-1:0] blk [N];
    logic [HASH_W-1:0]  ix  [N];
    logic [HASH_W-1:0]  ox  [N];
    logic [31:0]        exp_jobs = 0;

    bit                 core_silent = 1'b0;
    bit                 core_pend   = 1'b0;
    int                 core_cnt    = 0;
    logic               core_init_q = 1'b0;
    logic [HASH_W-1:0]  core_res    = '0;

    always #5 clk = ~clk;

    pbkdf2_2_sched #(
        .N_REQ(N),
        .INIT_CYCLES(INIT_CYC),
        .TIMEOUT(TMO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_data(req_data),
        .req_ixor(req_ixor),
        .req_oxor(req_oxor),
        .core_init(core_init),
        .core_in(core_in),
        .core_ixor_hash(core_ixor_hash),
        .core_oxor_hash(core_oxor_hash),
        .core_valid(core_valid),
        .core_out(core_out),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_data(rsp_data),
        .rsp_err(rsp_err),
        .busy(busy),
        .jobs_done(jobs_done)
    );

    // Core model: result CORE_LAT cycles after core_init rises; noise otherwise.
    always @(posedge clk) begin
        core_init_q <= core_init;
        core_valid  <= 1'b0;
        core_out    <= {8{$urandom()}};
        if (core_init === 1'b1 && core_init_q !== 1'b1 && !core_silent) begin
            core_pend <= 1'b1;
            core_cnt  <= 1;
            core_res  <= core_in[255:0] ^ core_ixor_hash;
        end else if (core_pend) begin
            if (core_cnt == CORE_LAT - 1) begin
                core_valid <= 1'b1;
                core_out   <= core_res;
                core_pend  <= 1'b0;
            end else begin
                core_cnt <= core_cnt + 1;
            end
        end
    end

    function automatic logic [HASH_W-1:0] model_result(input int id);
        logic [BLOCK_W-1:0] b;
        b = blk[id];
        return b[255:0] ^ ix[id];
    endfunction

    task automatic test_reset();
        rst       = 1'b1;
        req_valid = '0;
        rsp_ready = '0;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || rsp_valid !== '0 || req_ready !== '0) begin
            errors++;
            $display("FAIL reset_ctrl: busy=%b rsp_valid=%b req_ready=%b, required 0 0000 0000", busy, rsp_valid, req_ready);
        end
        checks++;
        if (jobs_done !== 32'd0 || rsp_err !== 1'b0 || rsp_data !== '0) begin
            errors++;
            $display("FAIL reset_rsp: jobs_done=%0d rsp_err=%b rsp_data=%h, required 0 0 0", jobs_done, rsp_err, rsp_data);
        end
        checks++;
        if (core_init !== 1'b0 || core_in !== '0 || core_ixor_hash !== '0 || core_oxor_hash !== '0) begin
            errors++;
            $display("FAIL reset_core: core_init=%b core_in_lo=%h ixor_lo=%h oxor_lo=%h, required all 0",
                     core_init, core_in[63:0], core_ixor_hash[63:0], core_oxor_hash[63:0]);
        end
        rst      = 1'b0;
        exp_jobs = 0;
    endtask

    task automatic test_single();
        int                n_init;
        int                t;
        bit                stable;
        logic [HASH_W-1:0] d0;
        exp_t              e;
        sb.push_back('{1, {32{8'hAA}}, 1'b0});
        req_valid = 4'b0010;
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin
            errors++;
            $display("FAIL single_ready: req_ready=%b, required 0010", req_ready);
        end
        @(negedge clk);
        req_valid = '0;
        checks++;
        if (core_init !== 1'b1 || busy !== 1'b1 || core_in !== blk[1] || core_ixor_hash !== ix[1] || core_oxor_hash !== ox[1]) begin
            errors++;
            $display("FAIL single_issue: core_init=%b busy=%b in_lo=%h ixor_lo=%h, required 1 1 %h %h",
                     core_init, busy, core_in[63:0], core_ixor_hash[63:0], blk[1][63:0], ix[1][63:0]);
        end
        n_init = 0;
        t      = 0;
        while (core_init === 1'b1 && t < 20) begin
            n_init++;
            t++;
            @(negedge clk);
        end
        checks++;
        if (n_init != INIT_CYC) begin
            errors++;
            $display("FAIL single_init_len: core_init high %0d cycles, required %0d", n_init, INIT_CYC);
        end
        checks++;
        if (core_in !== blk[1] || core_ixor_hash !== ix[1] || core_oxor_hash !== ox[1]) begin
            errors++;
            $display("FAIL single_hold: in_lo=%h ixor_lo=%h, required %h %h",
                     core_in[63:0], core_ixor_hash[63:0], blk[1][63:0], ix[1][63:0]);
        end
        t = 0;
        while (rsp_valid === '0 && t < 100) begin
            t++;
            @(negedge clk);
        end
        e = sb.pop_front();
        $display("rsp id=%0d valid=%b data=%h err=%b", e.id, rsp_valid, rsp_data, rsp_err);
        checks++;
        if (rsp_valid !== (N'(1) << e.id) || rsp_data !== e.data || rsp_err !== e.err) begin
            errors++;
            $display("FAIL single_rsp: valid=%b data=%h err=%b, required %b %h %b",
                     rsp_valid, rsp_data, rsp_err, N'(1) << e.id, e.data, e.err);
        end
        d0     = rsp_data;
        stable = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (rsp_valid !== 4'b0010 || rsp_data !== d0) stable = 1'b0;
        end
        checks++;
        if (!stable) begin
            errors++;
            $display("FAIL single_stall: rsp_valid/rsp_data changed while rsp_ready low (now %b %h), required 0010 %h",
                     rsp_valid, rsp_data, d0);
        end
        rsp_ready = 4'b0010;
        @(negedge clk);
        rsp_ready = '0;
        exp_jobs++;
        checks++;
        if (rsp_valid !== '0 || busy !== 1'b0 || jobs_done !== exp_jobs) begin
            errors++;
            $display("FAIL single_done: rsp_valid=%b busy=%b jobs_done=%0d, required 0000 0 %0d",
                     rsp_valid, busy, jobs_done, exp_jobs);
        end
    endtask

    task automatic test_round_robin();
        int   order [5] = '{0, 1, 2, 3, 0};
        int   t;
        exp_t e;
        rst = 1'b1;
        @(negedge clk);
        rst      = 1'b0;
        exp_jobs = 0;
        foreach (order[i]) sb.push_back('{order[i], model_result(order[i]), 1'b0});
        req_valid = '1;
        for (int k = 0; k < 5; k++) begin
            t = 0;
            while (rsp_valid === '0 && t < 100) begin
                t++;
                @(negedge clk);
            end
            e = sb.pop_front();
            $display("rsp id=%0d valid=%b data=%h err=%b", e.id, rsp_valid, rsp_data, rsp_err);
            checks++;
            if (rsp_valid !== (N'(1) << e.id)) begin
                errors++;
                $display("FAIL rr_grant%0d: rsp_valid=%b, required %b", k, rsp_valid, N'(1) << e.id);
            end
            checks++;
            if (rsp_data !== e.data || rsp_err !== 1'b0) begin
                errors++;
                $display("FAIL rr_data%0d: data=%h err=%b, required %h 0", k, rsp_data, rsp_err, e.data);
            end
            if (k == 4) req_valid = '0;
            rsp_ready = rsp_valid;
            @(negedge clk);
            rsp_ready = '0;
            exp_jobs++;
        end
        checks++;
        if (jobs_done !== exp_jobs) begin
            errors++;
            $display("FAIL rr_jobs: jobs_done=%0d, required %0d", jobs_done, exp_jobs);
        end
    endtask

    task automatic test_wrap();
        int   t;
        exp_t e;
        rst = 1'b1;
        @(negedge clk);
        rst      = 1'b0;
        exp_jobs = 0;
        sb.push_back('{0, model_result(0), 1'b0});
        sb.push_back('{3, model_result(3), 1'b0});
        req_valid = 4'b1001;
        for (int k = 0; k < 2; k++) begin
            t = 0;
            while (rsp_valid === '0 && t < 100) begin
                t++;
                @(negedge clk);
            end
            e = sb.pop_front();
            $display("rsp id=%0d valid=%b data=%h err=%b", e.id, rsp_valid, rsp_data, rsp_err);
            checks++;
            if (rsp_valid !== (N'(1) << e.id) || rsp_data !== e.data) begin
                errors++;
                $display("FAIL wrap_rsp%0d: valid=%b data=%h, required %b %h",
                         k, rsp_valid, rsp_data, N'(1) << e.id, e.data);
            end
            req_valid[e.id] = 1'b0;
            rsp_ready       = rsp_valid;
            @(negedge clk);
            rsp_ready = '0;
            exp_jobs++;
        end
        checks++;
        if (jobs_done !== exp_jobs) begin
            errors++;
            $display("FAIL wrap_jobs: jobs_done=%0d, required %0d", jobs_done, exp_jobs);
        end
    endtask

    task automatic test_timeout();
        int   t;
        int   n_wait;
        exp_t e;
        core_silent = 1'b1;
        sb.push_back('{2, '0, 1'b1});
        req_valid = 4'b0100;
        @(negedge clk);
        req_valid = '0;
        t = 0;
        while (core_init === 1'b1 && t < 20) begin
            t++;
            @(negedge clk);
        end
        n_wait = 0;
        while (rsp_valid === '0 && n_wait < 100) begin
            n_wait++;
            @(negedge clk);
        end
        checks++;
        if (n_wait != TMO) begin
            errors++;
            $display("FAIL timeout_len: %0d WAIT cycles before response, required %0d", n_wait, TMO);
        end
        e = sb.pop_front();
        $display("rsp id=%0d valid=%b data=%h err=%b", e.id, rsp_valid, rsp_data, rsp_err);
        checks++;
        if (rsp_valid !== (N'(1) << e.id) || rsp_data !== e.data || rsp_err !== e.err) begin
            errors++;
            $display("FAIL timeout_rsp: valid=%b data=%h err=%b, required %b %h %b",
                     rsp_valid, rsp_data, rsp_err, N'(1) << e.id, e.data, e.err);
        end
        rsp_ready = 4'b0100;
        @(negedge clk);
        rsp_ready = '0;
        checks++;
        if (jobs_done !== exp_jobs || busy !== 1'b0) begin
            errors++;
            $display("FAIL timeout_jobs: jobs_done=%0d busy=%b, required %0d 0", jobs_done, busy, exp_jobs);
        end
        core_silent = 1'b0;
    endtask

    task automatic test_reset_in_wait();
        int t;
        bit seen;
        req_valid = 4'b1000;
        @(negedge clk);
        req_valid = '0;
        t = 0;
        while (core_init === 1'b1 && t < 20) begin
            t++;
            @(negedge clk);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || core_in !== blk[3]) begin
            errors++;
            $display("FAIL rstwait_pre: busy=%b in_lo=%h, required 1 %h", busy, core_in[63:0], blk[3][63:0]);
        end
        rst = 1'b1;
        @(negedge clk);
        rst      = 1'b0;
        exp_jobs = 0;
        checks++;
        if (busy !== 1'b0 || rsp_valid !== '0 || rsp_err !== 1'b0 || rsp_data !== '0 || jobs_done !== 32'd0) begin
            errors++;
            $display("FAIL rstwait_rsp: busy=%b valid=%b err=%b data=%h jobs=%0d, required 0 0000 0 0 0",
                     busy, rsp_valid, rsp_err, rsp_data, jobs_done);
        end
        checks++;
        if (core_init !== 1'b0 || core_in !== '0 || core_ixor_hash !== '0 || core_oxor_hash !== '0) begin
            errors++;
            $display("FAIL rstwait_core: init=%b in_lo=%h ixor_lo=%h oxor_lo=%h, required all 0",
                     core_init, core_in[63:0], core_ixor_hash[63:0], core_oxor_hash[63:0]);
        end
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (rsp_valid !== '0 || busy !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL rstwait_quiet: response or busy after aborted job (valid=%b busy=%b), required none",
                     rsp_valid, busy);
        end
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < BLOCK_W / 32; j++) blk[i][j*32 +: 32] = $urandom();
            for (int j = 0; j < HASH_W / 32; j++) begin
                ix[i][j*32 +: 32] = $urandom();
                ox[i][j*32 +: 32] = $urandom();
            end
        end
        blk[1][255:0] = {32{8'hA5}};
        ix[1]         = {32{8'h0F}};
        for (int i = 0; i < N; i++) begin
            req_data[i*BLOCK_W +: BLOCK_W] = blk[i];
            req_ixor[i*HASH_W +: HASH_W]   = ix[i];
            req_oxor[i*HASH_W +: HASH_W]   = ox[i];
        end

        test_reset();
        test_single();
        test_round_robin();
        test_wrap();
        test_timeout();
        test_reset_in_wait();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pbkdf2_2_sched.md
PBKDF2_2_SCHED -- requirements
Module: pbkdf2_2_sched

Interface
REQ-001 Parameter N_REQ, default 4: number of ROMix requesters sharing one pbkdf2_2 core.
REQ-002 Parameter INIT_CYCLES, default 2: cycles core_init is held high per job.
REQ-003 Parameter TIMEOUT, default 4096: maximum WAIT cycles before abort.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 req_valid  in  N_REQ  per-requester job pending.
REQ-007 req_ready  out  N_REQ  one-hot accept strobe.
REQ-008 req_data  in  N_REQ*1024  per-requester ROMix output block; slice i = bits [i*1024+1023 : i*1024].
REQ-009 req_ixor, req_oxor  in  N_REQ*256 each  per-requester HMAC inner/outer state.
REQ-010 core_init  out  1  start to pbkdf2_2.
REQ-011 core_in  out  1024; core_ixor_hash, core_oxor_hash  out  256  core operands.
REQ-012 core_valid  in  1; core_out  in  256  core result.
REQ-013 rsp_valid  out  N_REQ  one-hot result valid; rsp_ready  in  N_REQ.
REQ-014 rsp_data  out  256; rsp_err  out  1 (timeout abort).
REQ-015 busy  out  1; jobs_done  out  32  completed-job counter.

Function
REQ-016 The FSM SHALL have states IDLE, ISSUE, WAIT and RESP.
REQ-017 IDLE: if any req_valid, the block SHALL drive req_ready one-hot (combinationally) at grant g, the first index with req_valid set searching upward from last_grant+1 with wrap from N_REQ-1 to 0.
REQ-018 On req_valid[g]&req_ready[g], the block SHALL latch data/ixor/oxor slice g and id g, then enter ISSUE next cycle.
REQ-019 ISSUE: core_init SHALL be 1 for exactly INIT_CYCLES consecutive cycles with core_in/ixor/oxor stable, then enter WAIT.
REQ-020 core operand outputs SHALL hold the latched values from ISSUE until leaving WAIT.
REQ-021 WAIT: on core_valid=1 the block SHALL latch core_out into rsp_data, clear rsp_err and enter RESP next cycle.
REQ-022 WAIT: a 16-bit counter SHALL start at 0 on entry; when it reaches TIMEOUT-1 without core_valid, set rsp_err=1, rsp_data=0 and enter RESP.
REQ-023 core_valid outside WAIT SHALL be ignored.
REQ-024 RESP: rsp_valid[id] SHALL be 1, others 0, held with rsp_data/rsp_err stable until rsp_ready[id]=1; then last_grant<=id, jobs_done increments (only when rsp_err=0, wrapping at 2^32-1 to 0) and state returns to IDLE.
REQ-025 req_ready SHALL be all-zero outside IDLE; requests arriving then wait.
REQ-026 busy SHALL be 1 in every state except IDLE.
REQ-027 Worst-case grant latency per requester SHALL be N_REQ-1 jobs (strict round-robin, no starvation).
REQ-028 Minimum job latency, accept to rsp_valid: INIT_CYCLES + core latency + 2 cycles.

Reset
REQ-029 rst SHALL set state IDLE, last_grant=N_REQ-1 (first grant to 0), jobs_done=0, rsp_err=0, rsp_data=0, core_in/ixor/oxor=0, core_init=0, rsp_valid=0, counter=0.
REQ-030 rst asserted in any state SHALL abort the job with no response; core_init SHALL deassert the following cycle.

Structure
REQ-031 State encoding and the default widths (1024, 256) SHALL reside in shared package scrypt_pkg.
REQ-032 Round-robin grant logic SHALL be sub-module rr_arbiter (params N_REQ; in req, last_grant; out grant one-hot, any).

Verification
REQ-033 Bench core model: latency 10 cycles, core_out = core_in[255:0] ^ core_ixor_hash.
REQ-034 Single job: req_valid=4'b0010, slice1 low 256 bits=0xA5..A5, ixor=0x0F..0F -> core_init high 2 cycles, rsp_valid=4'b0010 with rsp_data=0xAA..AA, jobs_done=1.
REQ-035 All four requesting continuously from reset -> grant order 0,1,2,3,0; each rsp_valid one-hot to matching id.
REQ-036 Wrap: last_grant=3, req_valid=4'b1001 -> grant 0, then 3.
REQ-037 Core silent, TIMEOUT=16 -> rsp_err=1, rsp_data=0 after 16 WAIT cycles; jobs_done unchanged.
REQ-038 rsp_ready held low 5 cycles -> rsp_valid/rsp_data stable; rst pulsed in WAIT -> IDLE, all outputs at reset values, no response.
